regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have parameter PEND_W, default 2, width of each per-register pending-write counter; PMAX = 2**PEND_W - 1.
REQ-004 SHALL have parameter R0_ZERO, default 1, meaning register 0 reads as zero and ignores writes.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 rs_addr, rt_addr  in  ADDR_W  read port indices.
REQ-009 rs_used, rt_used  in  1  the decoding instruction actually sources rs / rt.
REQ-010 qa, qb  out  DATA_W  read data for rs_addr / rt_addr.
REQ-011 we  in  1  write-back enable.
REQ-012 wn  in  ADDR_W  write-back index.
REQ-013 d  in  DATA_W  write-back data.
REQ-014 issue_valid  in  1  decoded instruction requests issue.
REQ-015 issue_wreg  in  1  issuing instruction will write a register.
REQ-016 issue_dst  in  ADDR_W  destination of the issuing instruction.
REQ-017 stall  out  1  issue blocked this cycle.
REQ-018 err  out  1  sticky write-without-pending error flag.

Function
REQ-019 Reads SHALL be combinational: qa = reg[rs_addr], qb = reg[rt_addr].
REQ-020 When we=1 and wn equals a read index, that port SHALL return d in the same cycle (write-through bypass).
REQ-021 With R0_ZERO=1, index 0 SHALL read 0, SHALL NOT be written or bypassed, and its counter SHALL remain 0.
REQ-022 On rising clk with we=1, reg[wn] SHALL take d.
REQ-023 Each register SHALL have a PEND_W-bit counter pend[i] of in-flight writes.
REQ-024 hazard_rs SHALL be rs_used and (pend[rs]>1, or pend[rs]=1 and not (we and wn=rs)); hazard_rt the same for rt.
REQ-025 full SHALL be issue_wreg and pend[issue_dst]=PMAX and not (we and wn=issue_dst).
REQ-026 stall SHALL be issue_valid and (hazard_rs or hazard_rt or full), combinationally.
REQ-027 issue SHALL be accepted when issue_valid=1 and stall=0; accepted with issue_wreg=1 increments pend[issue_dst].
REQ-028 we=1 with pend[wn]>0 SHALL decrement pend[wn].
REQ-029 An accepted increment and a decrement on the same index in one cycle SHALL leave pend unchanged.
REQ-030 we=1 with pend[wn]=0 SHALL still write data, leave pend at 0, and set err.
REQ-031 err SHALL stay set until reset.
REQ-032 A stalled issue SHALL change no counter; the caller holds its inputs until stall=0.
REQ-033 Counters SHALL never wrap: no increment at PMAX and no decrement at 0.

Reset
REQ-034 rst=1 SHALL immediately clear all registers to 0, all pend to 0, and err to 0, independent of clk.
REQ-035 During reset, stall SHALL follow REQ-026 using cleared counters, so it is 0 for any input.
REQ-036 Writes and issues in the cycle reset deasserts SHALL take effect only on the next rising edge after rst=0.

Verification
REQ-037 Write r5=0x12345678, then read rs=5 -> qa=0x12345678; same-cycle write r7=0xA5A5A5A5 with rt=7 -> qb=0xA5A5A5A5 that cycle.
REQ-038 Issue dst=3; next cycle rs=3, rs_used=1 -> stall=1; assert we, wn=3 that cycle -> stall=0 (single pending bypassed), pend[3]=0 afterwards.
REQ-039 Three issues to dst=4 with PEND_W=2 -> pend[4]=3; fourth issue -> stall=1 (full), pend stays 3; simultaneous we, wn=4 -> accepted, pend stays 3.
REQ-040 Write r0=0xFFFFFFFF with R0_ZERO=1 -> qa=0 for rs=0; issue dst=0 -> pend[0]=0 and no stall from rs=0.
REQ-041 we, wn=9 with pend[9]=0 -> reg[9] written, err=1 and held; assert rst mid-cycle -> err=0, r9=0, all pend=0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the read, write-back and issue signals shared by the register file
// scoreboard and its user. Outputs of the scoreboard are qa, qb, stall and err.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic              we;
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] d;
    logic              issue_valid;
    logic              issue_wreg;
    logic [ADDR_W-1:0] issue_dst;
    logic              stall;
    logic              err;

    // Issue handshake: an issue is accepted in any cycle with issue_valid=1 and
    // stall=0; while stall=1 the master holds issue_* and the read indices stable.
    modport master (
        output rs_addr, rt_addr, rs_used, rt_used, we, wn, d,
               issue_valid, issue_wreg, issue_dst,
        input  qa, qb, stall, err
    );

    modport slave (
        input  rs_addr, rt_addr, rs_used, rt_used, we, wn, d,
               issue_valid, issue_wreg, issue_dst,
        output qa, qb, stall, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-through read bypass and a per-register counter of
// in-flight writes that stalls issue on RAW hazards or counter saturation.
module regfile_scoreboard #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PEND_W  = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PMAX = '1;
    localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] pend [NREG];
    logic              err_q;

    logic wr_ok;
    logic hazard_rs;
    logic hazard_rt;
    logic full;
    logic stall_c;
    logic inc_ok;
    logic dec_ok;

    // Register 0 (when hard-wired) is invisible to writes, bypass and counters.
    assign wr_ok = bus.we && !((R0_ZERO != 0) && (bus.wn == '0));

    always_comb begin
        bus.qa = regs[bus.rs_addr];
        if (wr_ok && (bus.wn == bus.rs_addr)) bus.qa = bus.d;
        if ((R0_ZERO != 0) && (bus.rs_addr == '0)) bus.qa = '0;

        bus.qb = regs[bus.rt_addr];
        if (wr_ok && (bus.wn == bus.rt_addr)) bus.qb = bus.d;
        if ((R0_ZERO != 0) && (bus.rt_addr == '0)) bus.qb = '0;
    end

    // A single outstanding write retiring this cycle is covered by the bypass.
    assign hazard_rs = bus.rs_used &&
        ((pend[bus.rs_addr] > PONE) ||
         ((pend[bus.rs_addr] == PONE) && !(wr_ok && (bus.wn == bus.rs_addr))));
    assign hazard_rt = bus.rt_used &&
        ((pend[bus.rt_addr] > PONE) ||
         ((pend[bus.rt_addr] == PONE) && !(wr_ok && (bus.wn == bus.rt_addr))));
    assign full = bus.issue_wreg && (pend[bus.issue_dst] == PMAX) &&
                  !(wr_ok && (bus.wn == bus.issue_dst));

    assign stall_c   = bus.issue_valid && (hazard_rs || hazard_rt || full);
    assign bus.stall = stall_c;
    assign bus.err   = err_q;

    assign inc_ok = bus.issue_valid && !stall_c && bus.issue_wreg &&
                    !((R0_ZERO != 0) && (bus.issue_dst == '0));
    assign dec_ok = wr_ok && (pend[bus.wn] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_ok) regs[bus.wn] <= bus.d;
            if (wr_ok && (pend[bus.wn] == '0)) err_q <= 1'b1;
            // Increment is only accepted below PMAX or alongside a decrement,
            // and decrement only above 0, so counters never wrap.
            for (int i = 0; i < NREG; i++) begin
                if ((inc_ok && (bus.issue_dst == ADDR_W'(i))) &&
                    !(dec_ok && (bus.wn == ADDR_W'(i))))
                    pend[i] <= pend[i] + PONE;
                else if ((dec_ok && (bus.wn == ADDR_W'(i))) &&
                         !(inc_ok && (bus.issue_dst == ADDR_W'(i))))
                    pend[i] <= pend[i] - PONE;
            end
        end
    end
endmodule
